// File: rtl/sd_host_pkg.sv
// Shared constants for the SD host command-line engine: FSM encoding,
// response types, error bit positions, frame lengths and the CRC7 step.
package sd_host_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RECV  = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [1:0] RESP_NONE    = 2'b00;
    localparam logic [1:0] RESP_136     = 2'b01;
    localparam logic [1:0] RESP_48      = 2'b10;
    localparam logic [1:0] RESP_48_BUSY = 2'b11;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_CRC     = 1;
    localparam int ERR_END     = 2;
    localparam int ERR_INDEX   = 3;

    localparam int FRAME_LEN = 48;
    localparam int LONG_LEN  = 136;
    localparam int CRC_SPAN  = 40;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

endpackage

// File: rtl/sd_host_cmd_crc7.sv
// Serial CRC7 accumulator with synchronous clear and per-bit enable.
module sd_crc7
    import sd_host_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (enable)
            crc <= crc7_step(crc, data_in);
    end

endmodule

// File: rtl/sd_host_cmd.sv
// SD host CMD-line engine: serializes a 48-bit command frame, then captures
// and checks the card's 48/136-bit response.
module sd_host_cmd
    import sd_host_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int SYNC_STAGES  = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sd_clock,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    input  logic [31:0]  reg_024h_in,
    output logic [31:0]  reg_024h_out,
    input  logic [15:0]  reg_00eh_in,
    output logic [15:0]  reg_00eh_out,
    input  logic [15:0]  reg_008h_in,
    output logic [15:0]  reg_008h_out,
    input  logic [15:0]  reg_032h_in,
    output logic [15:0]  reg_032h_out,
    output logic [127:0] response_out
);

    localparam int TO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    logic [SYNC_STAGES-1:0] sd_sync_p0;
    logic [SYNC_STAGES-1:0] cmd_sync_p0;
    logic                   sd_prev_p1;
    logic                   sd_s, cmd_s, sd_rise, sd_fall;

    logic [2:0]   state;
    logic         req_prev;
    logic         inhibit, complete;
    logic [3:0]   raw_err;
    logic [39:0]  tx_sr;
    logic [5:0]   bit_cnt;
    logic [7:0]   rx_cnt;
    logic [7:0]   rx_len;
    logic [TO_W-1:0] to_cnt;
    logic [135:0] rx_sr;
    logic [6:0]   crc_tx, crc_rx;
    logic [2:0]   crc_idx;
    logic         tx_bit, launch, crc_tx_en, crc_rx_en;
    logic         unused_ok;

    // Synchronizer stage boundary
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sd_sync_p0  <= '0;
            cmd_sync_p0 <= '1;
            sd_prev_p1  <= 1'b0;
        end else begin
            sd_sync_p0  <= {sd_sync_p0[SYNC_STAGES-2:0], sd_clock};
            cmd_sync_p0 <= {cmd_sync_p0[SYNC_STAGES-2:0], cmd_pin_in};
            sd_prev_p1  <= sd_s;
        end
    end

    assign sd_s    = sd_sync_p0[SYNC_STAGES-1];
    assign cmd_s   = cmd_sync_p0[SYNC_STAGES-1];
    assign sd_rise = sd_s & ~sd_prev_p1;
    assign sd_fall = ~sd_s & sd_prev_p1;

    assign launch = (state == IDLE) && reg_024h_in[0] && !req_prev;
    assign rx_len = (reg_00eh_out[1:0] == RESP_136) ? 8'(LONG_LEN) : 8'(FRAME_LEN);

    always_comb begin
        crc_idx = 3'(6'd46 - bit_cnt);
        tx_bit  = 1'b1;
        if (bit_cnt < 6'(CRC_SPAN))
            tx_bit = tx_sr[39];
        else if (bit_cnt < 6'd47)
            tx_bit = crc_tx[crc_idx];
    end

    assign crc_tx_en = sd_fall && (state == SEND) && (bit_cnt < 6'(CRC_SPAN));
    assign crc_rx_en = sd_rise && (((state == WAIT) && !cmd_s) ||
                                   ((state == RECV) && (rx_cnt < 8'(CRC_SPAN))));

    sd_crc7 u_crc_tx (
        .clock   (clock),
        .reset   (reset),
        .clear   (launch),
        .enable  (crc_tx_en),
        .data_in (tx_sr[39]),
        .crc     (crc_tx)
    );

    sd_crc7 u_crc_rx (
        .clock   (clock),
        .reset   (reset),
        .clear   (launch),
        .enable  (crc_rx_en),
        .data_in (cmd_s),
        .crc     (crc_rx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_prev     <= 1'b0;
            cmd_pin_out  <= 1'b1;
            inhibit      <= 1'b0;
            complete     <= 1'b0;
            raw_err      <= '0;
            reg_00eh_out <= '0;
            reg_008h_out <= '0;
            response_out <= '0;
            tx_sr        <= '0;
            bit_cnt      <= '0;
            rx_cnt       <= '0;
            to_cnt       <= '0;
            rx_sr        <= '0;
        end else begin
            req_prev <= reg_024h_in[0];
            case (state)
                IDLE: if (launch) begin
                    reg_00eh_out <= reg_00eh_in;
                    reg_008h_out <= reg_008h_in;
                    tx_sr        <= {2'b01, reg_00eh_in[13:8], 16'h0000, reg_008h_in};
                    bit_cnt      <= '0;
                    rx_cnt       <= '0;
                    to_cnt       <= '0;
                    inhibit      <= 1'b1;
                    complete     <= 1'b0;
                    raw_err      <= '0;
                    response_out <= '0;
                    state        <= SEND;
                end
                // The end bit is held for a full sd period before leaving SEND.
                SEND: if (sd_fall) begin
                    if (bit_cnt == 6'(FRAME_LEN)) begin
                        cmd_pin_out <= 1'b1;
                        state       <= (reg_00eh_out[1:0] == RESP_NONE) ? DONE : WAIT;
                    end else begin
                        cmd_pin_out <= tx_bit;
                        bit_cnt     <= bit_cnt + 6'd1;
                        if (bit_cnt < 6'(CRC_SPAN))
                            tx_sr <= {tx_sr[38:0], 1'b0};
                    end
                end
                WAIT: if (sd_rise) begin
                    if (!cmd_s) begin
                        rx_sr  <= {rx_sr[134:0], cmd_s};
                        rx_cnt <= 8'd1;
                        state  <= RECV;
                    end else if (to_cnt == TO_W'(RESP_TIMEOUT - 1)) begin
                        raw_err[ERR_TIMEOUT] <= 1'b1;
                        state                <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RECV: if (sd_rise) begin
                    rx_sr  <= {rx_sr[134:0], cmd_s};
                    rx_cnt <= rx_cnt + 8'd1;
                    if (rx_cnt == rx_len - 8'd1)
                        state <= CHECK;
                end
                CHECK: begin
                    raw_err[ERR_END] <= ~rx_sr[0];
                    if (reg_00eh_out[1:0] == RESP_136) begin
                        response_out <= {8'h00, rx_sr[127:8]};
                    end else begin
                        response_out       <= {96'h0, rx_sr[39:8]};
                        raw_err[ERR_CRC]   <= reg_00eh_out[3] && (crc_rx != rx_sr[7:1]);
                        raw_err[ERR_INDEX] <= reg_00eh_out[4] && (rx_sr[45:40] != reg_00eh_out[13:8]);
                    end
                    state <= DONE;
                end
                DONE: begin
                    inhibit  <= 1'b0;
                    complete <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reg_024h_out = {15'h0, complete, 15'h0, inhibit};
    assign reg_032h_out = {12'h000, raw_err} & reg_032h_in;
    assign unused_ok    = ^{reg_024h_in[31:1], rx_sr[135:128]};

endmodule

// File: tb/tb_sd_host_cmd.sv
// Directed bench for sd_host_cmd: plays the card side of the CMD line.
module tb_sd_host_cmd;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sd_clock = 1'b0;
    logic         cmd_pin_in = 1'b1;
    logic         cmd_pin_out;
    logic [31:0]  reg_024h_in = '0;
    logic [31:0]  reg_024h_out;
    logic [15:0]  reg_00eh_in = '0;
    logic [15:0]  reg_00eh_out;
    logic [15:0]  reg_008h_in = '0;
    logic [15:0]  reg_008h_out;
    logic [15:0]  reg_032h_in = 16'h000F;
    logic [15:0]  reg_032h_out;
    logic [127:0] response_out;

    int errors = 0;
    int checks = 0;

    localparam logic [47:0] FRAME_CMD0 = 48'h40_00000000_95;
    localparam logic [47:0] FRAME_CMD8 = 48'h48_000001AA_87;

    sd_host_cmd dut (
        .clock        (clock),
        .reset        (reset),
        .sd_clock     (sd_clock),
        .cmd_pin_in   (cmd_pin_in),
        .cmd_pin_out  (cmd_pin_out),
        .reg_024h_in  (reg_024h_in),
        .reg_024h_out (reg_024h_out),
        .reg_00eh_in  (reg_00eh_in),
        .reg_00eh_out (reg_00eh_out),
        .reg_008h_in  (reg_008h_in),
        .reg_008h_out (reg_008h_out),
        .reg_032h_in  (reg_032h_in),
        .reg_032h_out (reg_032h_out),
        .response_out (response_out)
    );

    always #5 clock = ~clock;
    always #60 sd_clock = ~sd_clock;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_req(input logic [15:0] cmd, input logic [15:0] arg);
        @(negedge clock);
        reg_00eh_in = cmd;
        reg_008h_in = arg;
        reg_024h_in = 32'h1;
        repeat (2) @(negedge clock);
        reg_024h_in = 32'h0;
    endtask

    task automatic capture_frame(output logic [47:0] f, output logic ok);
        f  = '0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge sd_clock);
            if (cmd_pin_out === 1'b0) ok = 1'b1;
        end
        if (ok) begin
            for (int i = 46; i >= 0; i--) begin
                @(posedge sd_clock);
                f[i] = cmd_pin_out;
            end
        end
    endtask

    task automatic card_send(input logic [135:0] v, input int n);
        repeat (2) @(negedge sd_clock);
        for (int i = n - 1; i >= 0; i--) begin
            cmd_pin_in = v[i];
            @(negedge sd_clock);
        end
        cmd_pin_in = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (reg_024h_out[16] !== 1'b1 && n < 4000) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_done"}, 128'(reg_024h_out), 128'h0001_0000);
    endtask

    task automatic do_cmd(input string tag, input logic [15:0] cmd, input logic [15:0] arg,
                          input logic [47:0] exp_frame, input logic [135:0] reply, input int nbits);
        logic [47:0] f;
        logic        ok;
        pulse_req(cmd, arg);
        capture_frame(f, ok);
        check_eq({tag, "_start"}, 128'(ok), 128'h1);
        check_eq({tag, "_frame"}, 128'(f), 128'(exp_frame));
        if (nbits > 0) card_send(reply, nbits);
        wait_done(tag);
    endtask

    initial begin
        logic [47:0] f;
        logic        ok;
        int          n;

        repeat (3) @(negedge clock);
        check_eq("rst_pin", 128'(cmd_pin_out), 128'h1);
        check_eq("rst_024", 128'(reg_024h_out), 128'h0);
        check_eq("rst_032", 128'(reg_032h_out), 128'h0);
        check_eq("rst_resp", response_out, 128'h0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // CMD0, no response
        pulse_req(16'h0000, 16'h0000);
        @(negedge clock);
        check_eq("cmd0_busy", 128'(reg_024h_out), 128'h1);
        capture_frame(f, ok);
        check_eq("cmd0_start", 128'(ok), 128'h1);
        check_eq("cmd0_frame", 128'(f), 128'(FRAME_CMD0));
        wait_done("cmd0");
        check_eq("cmd0_err", 128'(reg_032h_out), 128'h0);

        // CMD8 with a clean R7 reply
        do_cmd("cmd8", 16'h081A, 16'h01AA, FRAME_CMD8, 136'h08_000001AA_13, 48);
        check_eq("cmd8_resp", response_out, 128'h0000_01AA);
        check_eq("cmd8_err", 128'(reg_032h_out), 128'h0);
        check_eq("cmd8_00e", 128'(reg_00eh_out), 128'h081A);
        check_eq("cmd8_008", 128'(reg_008h_out), 128'h01AA);

        // Timeout, enabled in the mask
        pulse_req(16'h081A, 16'h01AA);
        capture_frame(f, ok);
        check_eq("to_frame", 128'(f), 128'(FRAME_CMD8));
        repeat (60) @(posedge sd_clock);
        check_eq("to_early", 128'(reg_024h_out), 128'h1);
        wait_done("to");
        check_eq("to_err", 128'(reg_032h_out), 128'h1);

        // Timeout, masked off, then unmasked while the raw error persists
        reg_032h_in = 16'h0000;
        do_cmd("tom", 16'h081A, 16'h01AA, FRAME_CMD8, '0, 0);
        check_eq("tom_err", 128'(reg_032h_out), 128'h0);
        reg_032h_in = 16'h000F;
        #1;
        check_eq("tom_unmask", 128'(reg_032h_out), 128'h1);

        // Corrupt replies
        do_cmd("crc", 16'h081A, 16'h01AA, FRAME_CMD8, 136'h08_000001AA_15, 48);
        check_eq("crc_err", 128'(reg_032h_out), 128'h2);
        check_eq("crc_resp", response_out, 128'h0000_01AA);
        do_cmd("idx", 16'h0812, 16'h01AA, FRAME_CMD8, 136'h09_000001AA_13, 48);
        check_eq("idx_err", 128'(reg_032h_out), 128'h8);
        do_cmd("endb", 16'h081A, 16'h01AA, FRAME_CMD8, 136'h08_000001AA_12, 48);
        check_eq("endb_err", 128'(reg_032h_out), 128'h4);

        // 136-bit reply, index/CRC enables set but not applied
        pulse_req(16'h0219, 16'h0000);
        capture_frame(f, ok);
        check_eq("r136_start", 128'(ok), 128'h1);
        card_send({8'h3F, 128'h0123456789ABCDEF_FEDCBA9876543211}, 136);
        wait_done("r136");
        check_eq("r136_resp", response_out, 128'h00_0123456789ABCDEF_FEDCBA98765432);
        check_eq("r136_err", 128'(reg_032h_out), 128'h0);

        // Request edges while busy are ignored
        pulse_req(16'h0000, 16'h0000);
        fork
            capture_frame(f, ok);
            begin
                repeat (20) @(negedge clock);
                reg_00eh_in = 16'h3F1A;
                reg_008h_in = 16'hBEEF;
                reg_024h_in = 32'h1;
                repeat (4) @(negedge clock);
                reg_024h_in = 32'h0;
                repeat (4) @(negedge clock);
                reg_024h_in = 32'h1;
            end
        join
        check_eq("busy_frame", 128'(f), 128'(FRAME_CMD0));
        wait_done("busy");
        check_eq("busy_00e", 128'(reg_00eh_out), 128'h0);
        check_eq("busy_008", 128'(reg_008h_out), 128'h0);
        repeat (300) @(negedge clock);
        check_eq("busy_norelaunch", 128'(reg_024h_out), 128'h0001_0000);
        reg_024h_in = 32'h0;

        // Asynchronous reset in the middle of SEND
        pulse_req(16'h081A, 16'h01AA);
        n = 0;
        while (cmd_pin_out !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (40) @(negedge clock);
        check_eq("rst_pre", 128'(cmd_pin_out), 128'h0);
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_pin", 128'(cmd_pin_out), 128'h1);
        check_eq("mrst_024", 128'(reg_024h_out), 128'h0);
        check_eq("mrst_00e", 128'(reg_00eh_out), 128'h0);
        check_eq("mrst_008", 128'(reg_008h_out), 128'h0);
        check_eq("mrst_resp", response_out, 128'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        do_cmd("recover", 16'h0000, 16'h0000, FRAME_CMD0, '0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
